// File: rtl/div_arbiter.sv
// Shares one iterative divider between the two issue slots; slot 1 is older and always wins.
// Optional DIV_RESULT_CACHE_EN keeps the last divider result so a repeated operand set skips the divider.
module div_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_1,
  input  logic              req_2,
  input  logic              sign_1,
  input  logic              sign_2,
  input  logic [DATA_W-1:0] opa_1,
  input  logic [DATA_W-1:0] opb_1,
  input  logic [DATA_W-1:0] opa_2,
  input  logic [DATA_W-1:0] opb_2,
  output logic              div_start,
  output logic              div_sign,
  output logic [DATA_W-1:0] div_opa,
  output logic [DATA_W-1:0] div_opb,
  output logic              div_cancel,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_quo,
  input  logic [DATA_W-1:0] div_rem,
  output logic              stallreq_1,
  output logic              stallreq_2,
  output logic              res_valid_1,
  output logic              res_valid_2,
  output logic [DATA_W-1:0] quo_1,
  output logic [DATA_W-1:0] rem_1,
  output logic [DATA_W-1:0] quo_2,
  output logic [DATA_W-1:0] rem_2
);

  typedef enum logic [1:0] {IDLE, RUN1, RUN2, DONE} state_t;

  state_t            state;
  logic              pend2;
  logic              served_1;
  logic              running;
  logic              bypass;
  logic [DATA_W-1:0] byp_quo;
  logic [DATA_W-1:0] byp_rem;

  logic              sel_2;
  logic              l_sign;
  logic [DATA_W-1:0] l_opa;
  logic [DATA_W-1:0] l_opb;
  logic              l_byp;
  logic [DATA_W-1:0] l_quo;
  logic [DATA_W-1:0] l_rem;
  logic              hit;
  logic              fin;
  logic [DATA_W-1:0] fin_quo;
  logic [DATA_W-1:0] fin_rem;

`ifdef DIV_RESULT_CACHE_EN
  logic              cache_valid;
  logic              cache_sign;
  logic [DATA_W-1:0] cache_opa;
  logic [DATA_W-1:0] cache_opb;
  logic [DATA_W-1:0] cache_quo;
  logic [DATA_W-1:0] cache_rem;
  logic              cache_fill;
`endif

  // Operand set for the next launch: slot 2 when chaining out of RUN1 or when slot 1 is idle.
  always_comb begin
    sel_2  = (state == RUN1) || !req_1;
    l_sign = sel_2 ? sign_2 : sign_1;
    l_opa  = sel_2 ? opa_2 : opa_1;
    l_opb  = sel_2 ? opb_2 : opb_1;
    hit    = 1'b0;
    l_quo  = '1;
    l_rem  = l_opa;
`ifdef DIV_RESULT_CACHE_EN
    hit = cache_valid && (cache_sign == l_sign) && (cache_opa == l_opa) && (cache_opb == l_opb);
    if (hit) begin
      l_quo = cache_quo;
      l_rem = cache_rem;
    end
`endif
    l_byp = (l_opb == '0) || hit;
  end

  assign fin        = ((state == RUN1) || (state == RUN2)) && (bypass || (running && div_done));
  assign fin_quo    = bypass ? byp_quo : div_quo;
  assign fin_rem    = bypass ? byp_rem : div_rem;
  assign stallreq_1 = req_1 && !res_valid_1;
  assign stallreq_2 = req_2 && !res_valid_2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend2       <= 1'b0;
      served_1    <= 1'b0;
      running     <= 1'b0;
      bypass      <= 1'b0;
      byp_quo     <= '0;
      byp_rem     <= '0;
      div_start   <= 1'b0;
      div_sign    <= 1'b0;
      div_opa     <= '0;
      div_opb     <= '0;
      div_cancel  <= 1'b0;
      res_valid_1 <= 1'b0;
      res_valid_2 <= 1'b0;
      quo_1       <= '0;
      rem_1       <= '0;
      quo_2       <= '0;
      rem_2       <= '0;
    end else begin
      div_start   <= 1'b0;
      div_cancel  <= 1'b0;
      res_valid_1 <= 1'b0;
      res_valid_2 <= 1'b0;
      if (flush) begin
        // A divider result landing in the same cycle counts as finished, so no cancel is needed.
        state      <= IDLE;
        pend2      <= 1'b0;
        served_1   <= 1'b0;
        running    <= 1'b0;
        bypass     <= 1'b0;
        div_cancel <= running && !div_done;
      end else begin
        case (state)
          IDLE: begin
            if (req_1 || req_2) begin
              state     <= req_1 ? RUN1 : RUN2;
              pend2     <= req_1 && req_2;
              div_sign  <= l_sign;
              div_opa   <= l_opa;
              div_opb   <= l_opb;
              bypass    <= l_byp;
              byp_quo   <= l_quo;
              byp_rem   <= l_rem;
              running   <= !l_byp;
              div_start <= !l_byp;
            end
          end
          RUN1: begin
            if (fin) begin
              quo_1    <= fin_quo;
              rem_1    <= fin_rem;
              served_1 <= 1'b1;
              if (pend2) begin
                state     <= RUN2;
                pend2     <= 1'b0;
                div_sign  <= l_sign;
                div_opa   <= l_opa;
                div_opb   <= l_opb;
                bypass    <= l_byp;
                byp_quo   <= l_quo;
                byp_rem   <= l_rem;
                running   <= !l_byp;
                div_start <= !l_byp;
              end else begin
                state       <= DONE;
                res_valid_1 <= 1'b1;
                running     <= 1'b0;
                bypass      <= 1'b0;
              end
            end
          end
          RUN2: begin
            if (fin) begin
              quo_2       <= fin_quo;
              rem_2       <= fin_rem;
              state       <= DONE;
              res_valid_1 <= served_1;
              res_valid_2 <= 1'b1;
              running     <= 1'b0;
              bypass      <= 1'b0;
            end
          end
          DONE: begin
            state    <= IDLE;
            served_1 <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DIV_RESULT_CACHE_EN
  assign cache_fill = running && div_done && !flush;

  // Only genuine divider completions are remembered; flush leaves the entry intact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
      cache_sign  <= 1'b0;
      cache_opa   <= '0;
      cache_opb   <= '0;
      cache_quo   <= '0;
      cache_rem   <= '0;
    end else if (cache_fill) begin
      cache_valid <= 1'b1;
      cache_sign  <= div_sign;
      cache_opa   <= div_opa;
      cache_opb   <= div_opb;
      cache_quo   <= div_quo;
      cache_rem   <= div_rem;
    end
  end
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider plus a transaction-level latency/result model.
module tb_div_arbiter;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              req_1 = 1'b0;
  logic              req_2 = 1'b0;
  logic              sign_1 = 1'b0;
  logic              sign_2 = 1'b0;
  logic [DATA_W-1:0] opa_1 = '0;
  logic [DATA_W-1:0] opb_1 = '0;
  logic [DATA_W-1:0] opa_2 = '0;
  logic [DATA_W-1:0] opb_2 = '0;
  logic              div_done = 1'b0;
  logic [DATA_W-1:0] div_quo = '0;
  logic [DATA_W-1:0] div_rem = '0;
  logic              div_start;
  logic              div_sign;
  logic [DATA_W-1:0] div_opa;
  logic [DATA_W-1:0] div_opb;
  logic              div_cancel;
  logic              stallreq_1;
  logic              stallreq_2;
  logic              res_valid_1;
  logic              res_valid_2;
  logic [DATA_W-1:0] quo_1;
  logic [DATA_W-1:0] rem_1;
  logic [DATA_W-1:0] quo_2;
  logic [DATA_W-1:0] rem_2;

  div_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_1(req_1), .req_2(req_2), .sign_1(sign_1), .sign_2(sign_2),
    .opa_1(opa_1), .opb_1(opb_1), .opa_2(opa_2), .opb_2(opb_2),
    .div_start(div_start), .div_sign(div_sign), .div_opa(div_opa), .div_opb(div_opb),
    .div_cancel(div_cancel), .div_done(div_done), .div_quo(div_quo), .div_rem(div_rem),
    .stallreq_1(stallreq_1), .stallreq_2(stallreq_2),
    .res_valid_1(res_valid_1), .res_valid_2(res_valid_2),
    .quo_1(quo_1), .rem_1(rem_1), .quo_2(quo_2), .rem_2(rem_2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  int          dv_cnt = 0;
  int          dv_lat = 1;
  int          start_cnt = 0;
  int          cancel_cnt = 0;
  bit          inject_done = 1'b0;
  logic        dv_s = 1'b0;
  logic [31:0] dv_a = '0;
  logic [31:0] dv_b = '0;

  bit          cv = 1'b0;
  logic        cs = 1'b0;
  logic [31:0] ca = '0;
  logic [31:0] cb = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic bit cacheHit(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_RESULT_CACHE_EN
    return cv && (cs == s) && (ca == a) && (cb == b);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: the behavioural divider reacts at the falling edge, away from the DUT's edge.
  task automatic tick();
    @(negedge clk);
    div_done = 1'b0;
    if (!rst_n) begin
      dv_cnt = 0;
    end else begin
      if (inject_done) begin
        div_done    = 1'b1;
        div_quo     = 32'hDEAD;
        div_rem     = 32'hBEEF;
        inject_done = 1'b0;
      end else if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          div_done = 1'b1;
          {div_quo, div_rem} = refDiv(dv_s, dv_a, dv_b);
        end
      end
      if (div_cancel) begin
        dv_cnt = 0;
        cancel_cnt++;
      end
      if (div_start) begin
        dv_cnt = dv_lat;
        dv_s   = div_sign;
        dv_a   = div_opa;
        dv_b   = div_opb;
        start_cnt++;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input bit r1, input bit r2,
                               input logic s1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic s2, input logic [31:0] a2, input logic [31:0] b2,
                               input int lat);
    bit          byp1, byp2, fs, got;
    int          exp_lat, exp_starts, s0, n, stall_bad;
    logic [63:0] e1, e2;
    byp1 = (b1 == 32'd0) || cacheHit(s1, a1, b1);
    if (r1 && !byp1) begin cv = 1'b1; cs = s1; ca = a1; cb = b1; end
    byp2 = (b2 == 32'd0) || cacheHit(s2, a2, b2);
    if (r2 && !byp2) begin cv = 1'b1; cs = s2; ca = a2; cb = b2; end
    exp_lat = 1;
    exp_starts = 0;
    if (r1) begin exp_lat += byp1 ? 1 : lat + 1; if (!byp1) exp_starts++; end
    if (r2) begin exp_lat += byp2 ? 1 : lat + 1; if (!byp2) exp_starts++; end
    fs = r1 ? !byp1 : !byp2;
    e1 = refDiv(s1, a1, b1);
    e2 = refDiv(s2, a2, b2);
    dv_lat = lat;
    s0 = start_cnt;
    req_1 = r1; sign_1 = s1; opa_1 = a1; opb_1 = b1;
    req_2 = r2; sign_2 = s2; opa_2 = a2; opb_2 = b2;
    n = 0; got = 1'b0; stall_bad = 0;
    while (!got && n < 200) begin
      tick();
      n++;
      if (n == 1) checkOutput({tag, " start"}, 32'(div_start), 32'(fs));
      if (res_valid_1 || res_valid_2) got = 1'b1;
      else if (stallreq_1 !== r1 || stallreq_2 !== r2) stall_bad++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, " stall held"}, 32'(stall_bad), 32'd0);
    checkOutput({tag, " valid"}, 32'({res_valid_1, res_valid_2}), 32'({r1, r2}));
    checkOutput({tag, " stall release"}, 32'({stallreq_1, stallreq_2}), 32'd0);
    if (r1) begin
      checkOutput({tag, " quo_1"}, quo_1, e1[63:32]);
      checkOutput({tag, " rem_1"}, rem_1, e1[31:0]);
    end
    if (r2) begin
      checkOutput({tag, " quo_2"}, quo_2, e2[63:32]);
      checkOutput({tag, " rem_2"}, rem_2, e2[31:0]);
    end
    req_1 = 1'b0;
    req_2 = 1'b0;
    tick();
    checkOutput({tag, " valid pulse"}, 32'({res_valid_1, res_valid_2}), 32'd0);
    checkOutput({tag, " starts"}, 32'(start_cnt - s0), 32'(exp_starts));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          s0, c0, seen;
    bit          r1, r2;
    logic        s1, s2;
    logic [31:0] a1, b1, a2, b2;

    tick();
    tick();
    checkOutput("reset ctl", 32'({div_start, div_cancel, div_sign, res_valid_1, res_valid_2,
                                  stallreq_1, stallreq_2}), 32'd0);
    checkOutput("reset opa", div_opa, 32'd0);
    checkOutput("reset quo_1", quo_1, 32'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus("slot1 100/7", 1, 0, 0, 32'd100, 32'd7, 0, 32'd0, 32'd1, 3);
    applyStimulus("repeat 100/7", 1, 0, 0, 32'd100, 32'd7, 0, 32'd0, 32'd1, 3);
    applyStimulus("both", 1, 1, 0, 32'd100, 32'd7, 1, -32'sd9, 32'd2, 2);
    applyStimulus("zero div", 0, 1, 0, 32'd0, 32'd1, 0, 32'd5, 32'd0, 4);

    // Flush while slot 1 is in the divider, then a stray late completion.
    dv_lat = 10;
    s0 = start_cnt;
    c0 = cancel_cnt;
    sign_1 = 1'b0; opa_1 = 32'd100; opb_1 = 32'd7; req_1 = 1'b1;
    repeat (3) tick();
    flush = 1'b1;
    req_1 = 1'b0;
    tick();
    flush = 1'b0;
    checkOutput("flush cancel", 32'(div_cancel), 32'd1);
    checkOutput("flush valid", 32'({res_valid_1, res_valid_2}), 32'd0);
    tick();
    checkOutput("flush cancel pulse", 32'(div_cancel), 32'd0);
    inject_done = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (res_valid_1 || res_valid_2 || div_start) seen++;
    end
    checkOutput("late done ignored", 32'(seen), 32'd0);
    checkOutput("flush starts", 32'(start_cnt - s0), 32'd1);
    checkOutput("flush cancels", 32'(cancel_cnt - c0), 32'd1);

    // Flush coinciding with div_done discards the result.
    dv_lat = 3;
    opa_1 = 32'd1000; opb_1 = 32'd3; req_1 = 1'b1;
    repeat (4) tick();
    flush = 1'b1;
    req_1 = 1'b0;
    seen = 0;
    tick();
    flush = 1'b0;
    if (res_valid_1 || res_valid_2) seen++;
    repeat (3) begin
      tick();
      if (res_valid_1 || res_valid_2) seen++;
    end
    checkOutput("flush+done discard", 32'(seen), 32'd0);

    // Reset while slot 2 is in the divider.
    dv_lat = 4;
    c0 = cancel_cnt;
    sign_1 = 1'b0; opa_1 = 32'd300; opb_1 = 32'd11; req_1 = 1'b1;
    sign_2 = 1'b1; opa_2 = -32'sd50; opb_2 = 32'd3; req_2 = 1'b1;
    repeat (7) tick();
    checkOutput("pre-reset stall_2", 32'(stallreq_2), 32'd1);
    checkOutput("pre-reset quo_1", quo_1, 32'd27);
    rst_n = 1'b0;
    req_1 = 1'b0;
    req_2 = 1'b0;
    tick();
    cv = 1'b0;
    checkOutput("mid rst ctl", 32'({div_start, div_cancel, div_sign, res_valid_1, res_valid_2,
                                    stallreq_1, stallreq_2}), 32'd0);
    checkOutput("mid rst opa", div_opa, 32'd0);
    checkOutput("mid rst opb", div_opb, 32'd0);
    checkOutput("mid rst quo_1", quo_1, 32'd0);
    checkOutput("mid rst rem_1", rem_1, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("mid rst no cancel", 32'(cancel_cnt - c0), 32'd0);
    applyStimulus("after reset", 1, 0, 0, 32'd100, 32'd7, 0, 32'd0, 32'd1, 2);

    for (int i = 0; i < 40; i++) begin
      int k;
      k  = $urandom_range(1, 3);
      r1 = k[0];
      r2 = k[1];
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      a1 = $urandom;
      a2 = $urandom;
      k  = $urandom_range(0, 4);
      b1 = (k == 0) ? 32'd0 : ((k == 1) ? 32'($urandom) : 32'($urandom_range(1, 50)));
      k  = $urandom_range(0, 4);
      b2 = (k == 0) ? 32'd0 : ((k == 1) ? 32'($urandom) : 32'($urandom_range(1, 50)));
      if (a1 == 32'h8000_0000) a1 = 32'd1;
      if (a2 == 32'h8000_0000) a2 = 32'd1;
      applyStimulus("random", r1, r2, s1, a1, b1, s2, a2, b2, $urandom_range(1, 6));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
# div_arbiter

Schedules the single shared iterative divider between the two issue slots of the dual-issue pipeline. It sits beside the EX stages, accepts divide requests from slot 1 and slot 2, and drives the divider through a start/done handshake. It raises per-slot stall requests to the pipeline controller until the results are ready. Slot 1 is the older instruction and always wins.

## Interface
- DATA_W, 32, operand/result width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush from controller; aborts any operation
- req_1 / req_2  in  1  slot divide request; held stable while the slot is stalled
- sign_1 / sign_2  in  1  1 = signed divide
- opa_1 / opa_2  in  DATA_W  dividend
- opb_1 / opb_2  in  DATA_W  divisor
- div_start  out  1  one-cycle start pulse to the divider
- div_sign  out  1  signed flag to the divider
- div_opa / div_opb  out  DATA_W  operands to the divider, registered, stable from start until done
- div_cancel  out  1  one-cycle abort pulse to the divider
- div_done  in  1  divider result valid, one-cycle pulse
- div_quo / div_rem  in  DATA_W  divider quotient and remainder
- stallreq_1 / stallreq_2  out  1  stall request to the controller
- res_valid_1 / res_valid_2  out  1  slot result valid, one cycle
- quo_1, rem_1, quo_2, rem_2  out  DATA_W  slot results, registered

## Operation
- States: IDLE, RUN1, RUN2, DONE.
- IDLE:
  - req_1 → RUN1 and latch slot-1 operands. Set pend2 = req_2.
  - Else req_2 → RUN2 and latch slot-2 operands.
- RUN1 with div_done: latch quo_1/rem_1. If pend2 → RUN2 (latch slot-2 operands), else → DONE.
- RUN2 with div_done: latch quo_2/rem_2 → DONE.
- DONE:
  - Assert res_valid_x for each slot served in this sequence; both assert together when both were served.
  - Next state is always IDLE.
- stallreq_x = req_x && !res_valid_x, combinational. Both slots release in the same DONE cycle.
- Divisor zero: the divider is bypassed and no div_start is issued. Result is quo = all ones and rem = dividend. The state goes directly to the next RUN or DONE on the following cycle.
- flush has priority over everything:
  - Next state IDLE; pend2 and served flags clear.
  - res_valid_x are 0 in the next cycle.
  - div_cancel pulses if the state was RUN1 or RUN2 with the divider started and not done.
- A div_done arriving in IDLE or DONE, or a late div_done after a cancel, is ignored.
- Reset values:
  - All outputs are 0.
  - State is IDLE; pend2, served flags and the cache valid bit are 0.

## Timing
- Request sampled at edge t. The state enters RUN at t+1, and div_start is high for exactly the cycle after entry (t+1).
- div_done at cycle d:
  - RUN1 only: DONE at d+1, res_valid_1 high during d+1.
  - Pending slot 2: RUN2 at d+1, second start at d+1.
- Minimum latency request → res_valid is divider latency + 2 cycles; a zero divisor gives 2 cycles.
- With req held across DONE, a new request is re-sampled in IDLE at DONE+1. A held request is never served twice because the pipeline advances on the DONE cycle.
- Simultaneous flush and div_done: flush wins and the result is discarded.
- Reset mid-operation: IDLE next cycle and no div_cancel is issued; the divider is reset by the same rst_n.

## Configuration
- DIV_RESULT_CACHE_EN:
  - When defined, a one-entry cache holds the last {sign, opa, opb, quo, rem} from a completed divider run.
  - A request whose sign, opa and opb match a valid entry skips the divider and is treated like the zero-divisor bypass (2-cycle latency). This covers a div followed by a mod on the same operands.
  - The cache stays valid across flush and is cleared only by reset.
  - When undefined, every non-zero-divisor request starts the divider.

## Test plan
- Slot 1 only: req_1, opa=100, opb=7, unsigned.
  - Expect div_start one cycle after sampling.
  - After div_done: res_valid_1 for one cycle with quo_1=14 and rem_1=2. stallreq_1 falls that same cycle.
- Both slots in the same cycle: slot 1 = 100/7, slot 2 = -9/2 signed.
  - Expect two div_start pulses, slot 1 first.
  - Then one DONE cycle with res_valid_1 and res_valid_2 both high, quo_2=-4 and rem_2=-1. Both stallreqs stay high until then.
- Zero divisor: req_2, opa=5, opb=0.
  - Expect no div_start.
  - res_valid_2 two cycles after sampling, with quo_2=0xFFFFFFFF and rem_2=5.
- Flush during RUN1, before div_done:
  - Expect div_cancel for one cycle, state IDLE and no res_valid.
  - A late div_done is ignored.
- With DIV_RESULT_CACHE_EN: 100/7 completes, then a new req_1 with the same operands.
  - Expect no div_start and res_valid_1 after 2 cycles with 14/2.
  - Without the macro, div_start is issued.
- rst_n low during RUN2 → all outputs 0 the next cycle, and the arbiter accepts a new request in the cycle after release.
